// File: rtl/sccb_config_sequencer.sv
// SCCB master that walks a synchronous register ROM (1-cycle latency) and writes each entry as ID/reg/data.
// Build macro SCCB_ACK_CHECK_EN adds ACK sampling with three attempts per entry and a sticky nack_o.
module sccb_config_sequencer #(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned SCCB_FREQ_HZ   = 100_000,
    parameter logic [7:0]  DEVICE_ADDR    = 8'h42,
    parameter int unsigned ROM_ADDR_WIDTH = 8,
    parameter int unsigned DELAY_CYCLES   = 1_000_000
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [15:0]               rom_data_i,
    output logic                      sioc_o,
    output logic                      siod_o,
    output logic                      siod_oe_o,
    input  logic                      siod_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      nack_o,
    output logic [ROM_ADDR_WIDTH-1:0] write_count_o
);
    localparam int unsigned QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int unsigned DW  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_START, S_BIT, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [QW-1:0]             qcnt_q, qcnt_d;
    logic [1:0]                phase_q, phase_d;
    logic [3:0]                bit_q, bit_d;
    logic [1:0]                byte_q, byte_d;
    logic [DW-1:0]             dly_q, dly_d;
    logic [15:0]               entry_q, entry_d;
    logic [ROM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ROM_ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                      busy_q, busy_d, done_q, done_d, nack_q, nack_d;
    logic                      sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;
    logic                      qtr_end, advance, count_it;
    logic [7:0]                byte_val;
`ifdef SCCB_ACK_CHECK_EN
    logic [1:0]                retry_q, retry_d;
    logic                      nak_seen_q, nak_seen_d;
`else
    wire                       unused_siod = siod_i;
`endif

    assign qtr_end = (qcnt_q == QW'(QTR - 1));

    always_comb begin
        state_d  = state_q;
        qcnt_d   = qcnt_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        dly_d    = dly_q;
        entry_d  = entry_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        nack_d   = nack_q;
        advance  = 1'b0;
        count_it = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
        retry_d    = retry_q;
        nak_seen_d = nak_seen_q;
`endif
        if (state_q == S_START || state_q == S_BIT || state_q == S_STOP || state_q == S_GAP) begin
            qcnt_d = qtr_end ? '0 : qcnt_q + 1'b1;
            if (qtr_end) phase_d = phase_q + 2'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    done_d  = 1'b0;
                    nack_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef SCCB_ACK_CHECK_EN
                    retry_d = 2'd0;
`endif
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data_i == 16'hFFFF) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (rom_data_i == 16'hFFF0) begin
                    state_d = S_DELAY;
                    dly_d   = '0;
                end else begin
                    state_d = S_START;
                    entry_d = rom_data_i;
`ifdef SCCB_ACK_CHECK_EN
                    nak_seen_d = 1'b0;
`endif
                end
            end
            S_DELAY: begin
                if (dly_q == DW'(DELAY_CYCLES - 1)) advance = 1'b1;
                else                                 dly_d   = dly_q + 1'b1;
            end
            S_START: begin
                if (qtr_end && phase_q == 2'd1) begin
                    state_d = S_BIT;
                    bit_d   = 4'd0;
                    byte_d  = 2'd0;
                end
            end
            S_BIT: begin
`ifdef SCCB_ACK_CHECK_EN
                // First clock of Q2 is the SIOC rising edge of the acknowledge slot.
                if (bit_q == 4'd8 && phase_q == 2'd2 && qcnt_q == '0 && siod_i) nak_seen_d = 1'b1;
`endif
                if (qtr_end && phase_q == 2'd3) begin
                    if (bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (byte_q == 2'd2) state_d = S_STOP;
                        else                byte_d  = byte_q + 2'd1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_STOP: if (qtr_end && phase_q == 2'd2) state_d = S_GAP;
            S_GAP: begin
                if (qtr_end && phase_q == 2'd3) begin
`ifdef SCCB_ACK_CHECK_EN
                    if (nak_seen_q) begin
                        if (retry_q == 2'd2) begin
                            nack_d  = 1'b1;
                            retry_d = 2'd0;
                            advance = 1'b1;
                        end else begin
                            retry_d = retry_q + 2'd1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        retry_d  = 2'd0;
                        count_it = 1'b1;
                        advance  = 1'b1;
                    end
`else
                    count_it = 1'b1;
                    advance  = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (count_it) wcnt_d = wcnt_q + 1'b1;
        // The last table slot ends the run instead of wrapping back to entry 0.
        if (advance) begin
            if (&addr_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end
        end
        if (state_d != state_q) begin
            qcnt_d  = '0;
            phase_d = 2'd0;
        end
    end

    always_comb begin
        case (byte_d)
            2'd0:    byte_val = DEVICE_ADDR;
            2'd1:    byte_val = entry_d[15:8];
            default: byte_val = entry_d[7:0];
        endcase
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            S_START: begin
                oe_d   = 1'b1;
                siod_d = (phase_d == 2'd0);
            end
            S_BIT: begin
                sioc_d = phase_d[1];
                if (bit_d != 4'd8) begin
                    oe_d   = 1'b1;
                    siod_d = byte_val[3'd7 - bit_d[2:0]];
                end
            end
            S_STOP: begin
                sioc_d = (phase_d != 2'd0);
                if (phase_d != 2'd2) begin
                    oe_d   = 1'b1;
                    siod_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            phase_q <= 2'd0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            dly_q   <= '0;
            entry_q <= 16'h0000;
            addr_q  <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
            oe_q    <= 1'b0;
`ifdef SCCB_ACK_CHECK_EN
            retry_q    <= 2'd0;
            nak_seen_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            dly_q   <= dly_d;
            entry_q <= entry_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
            sioc_q  <= sioc_d;
            siod_q  <= siod_d;
            oe_q    <= oe_d;
`ifdef SCCB_ACK_CHECK_EN
            retry_q    <= retry_d;
            nak_seen_q <= nak_seen_d;
`endif
        end
    end

    assign rom_addr_o    = addr_q;
    assign write_count_o = wcnt_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign nack_o        = nack_q;
    assign sioc_o        = sioc_q;
    assign siod_o        = siod_q;
    assign siod_oe_o     = oe_q;
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench: registered ROM model, SCCB slave/monitor with protocol checks, per-scenario tasks.
module tb_sccb_config_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr, write_count;
    logic [15:0] rom_data = 16'hFFFF;
    logic        sioc, siod, siod_oe, busy, done, nack;
    logic        ack_pull = 1'b0;
    logic        nack_reg12 = 1'b0;
    wire         bus = siod_oe ? siod : ~ack_pull;
    logic [15:0] rom_tab [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       sioc_p = 1'b1, bus_p = 1'b1, b;
    int         bitcnt = 0, bytecnt = 3;
    logic [7:0] shreg = 8'h00;
    logic [7:0] rx [0:2];
    int         starts = 0, stops = 0, rises = 0, viol = 0;
    int         last_stop_cyc = 0, last_gap = 0, last_rise = 0;
    int         per_min = 1000000, per_max = 0;

    sccb_config_sequencer #(
        .CLK_FREQ_HZ(400), .SCCB_FREQ_HZ(10), .DEVICE_ADDR(8'h42),
        .ROM_ADDR_WIDTH(8), .DELAY_CYCLES(50)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .sioc_o(sioc), .siod_o(siod), .siod_oe_o(siod_oe), .siod_i(bus),
        .busy_o(busy), .done_o(done), .nack_o(nack), .write_count_o(write_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) rom_data <= rom_tab[rom_addr];

    // Slave + monitor: decodes bytes, drives ACK, flags SIOD edges while SIOC is high outside START/STOP.
    always @(negedge clk) begin
        b = siod_oe ? siod : ~ack_pull;
        if (reset) begin
            bytecnt  = 3;
            bitcnt   = 0;
            ack_pull = 1'b0;
        end else begin
            if (sioc_p && sioc && bus_p != b) begin
                if (bytecnt != 3) viol++;
                if (bus_p && !b) begin
                    starts++;
                    if (stops > 0) last_gap = cyc - last_stop_cyc;
                    bitcnt  = 0;
                    bytecnt = 0;
                end else begin
                    stops++;
                    last_stop_cyc = cyc;
                end
            end
            if (!sioc_p && sioc) begin
                rises++;
                if (bytecnt < 3) begin
                    if (bitcnt != 0) begin
                        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                    end
                    last_rise = cyc;
                    if (bitcnt < 8) shreg = {shreg[6:0], b};
                    else begin
                        if (siod_oe) viol++;
                        rx[bytecnt] = shreg;
                        bytecnt++;
                    end
                    bitcnt = (bitcnt == 8) ? 0 : bitcnt + 1;
                end
            end
            if (sioc_p && !sioc) begin
                ack_pull = 1'b0;
                if (bytecnt < 3 && bitcnt == 8)
                    ack_pull = !(nack_reg12 && bytecnt == 1 && shreg == 8'h12);
            end
        end
        sioc_p = sioc;
        bus_p  = siod_oe ? siod : ~ack_pull;
    end

    task automatic load(input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
        for (int i = 0; i < 256; i++) rom_tab[i] = 16'hFFFF;
        rom_tab[0] = e0; rom_tab[1] = e1; rom_tab[2] = e2; rom_tab[3] = e3;
    endtask

    task automatic clear_mon();
        starts = 0; stops = 0; last_gap = 0; per_min = 1000000; per_max = 0;
        rx[0] = 8'h00; rx[1] = 8'h00; rx[2] = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({sioc, siod, siod_oe} !== 3'b110) begin
            errors++;
            $display("FAIL reset_bus got sioc/siod/oe=%b required 110", {sioc, siod, siod_oe});
        end
        checks++;
        if ({busy, done, nack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status got busy/done/nack=%b required 000", {busy, done, nack});
        end
        checks++;
        if (rom_addr !== 8'd0 || write_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters got addr=%0d count=%0d required 0 0", rom_addr, write_count);
        end
    endtask

    task automatic test_single_write();
        load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        clear_mon();
        pulse_start();
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL single_launch got busy/done=%b required 10", {busy, done});
        end
        wait_done(3000);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done=%b busy=%b required 1 0", done, busy);
        end
        checks++;
        if ({rx[0], rx[1], rx[2]} !== 24'h421280) begin
            errors++;
            $display("FAIL single_bytes got %h%h%h required 421280", rx[0], rx[1], rx[2]);
        end
        checks++;
        if (starts !== 1 || stops !== 1) begin
            errors++;
            $display("FAIL single_framing got starts=%0d stops=%0d required 1 1", starts, stops);
        end
        checks++;
        if (write_count !== 8'd1) begin
            errors++;
            $display("FAIL single_count got %0d required 1", write_count);
        end
        checks++;
        if (per_min !== 40 || per_max !== 40) begin
            errors++;
            $display("FAIL sioc_period got min=%0d max=%0d required 40 40", per_min, per_max);
        end
    endtask

    task automatic test_delay();
        load(16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF);
        clear_mon();
        pulse_start();
        wait_done(5000);
        checks++;
        if (done !== 1'b1 || write_count !== 8'd2) begin
            errors++;
            $display("FAIL delay_count got done=%b count=%0d required 1 2", done, write_count);
        end
        checks++;
        if (starts !== 2 || {rx[0], rx[1], rx[2]} !== 24'h421101) begin
            errors++;
            $display("FAIL delay_second got starts=%0d bytes=%h%h%h required 2 421101",
                     starts, rx[0], rx[1], rx[2]);
        end
        // STOP edge + 10 (rest of STOP) + 40 (GAP) + 50 (delay) is the minimum spacing.
        checks++;
        if (last_gap < 100) begin
            errors++;
            $display("FAIL delay_gap got %0d clocks required >= 100", last_gap);
        end
        checks++;
        if (rom_addr !== 8'd3) begin
            errors++;
            $display("FAIL delay_end_addr got %0d required 3", rom_addr);
        end
    endtask

    task automatic test_back_to_back();
        load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        clear_mon();
        pulse_start();
        repeat (200) @(negedge clk);
        pulse_start();
        wait_done(3000);
        checks++;
        if (starts !== 1 || write_count !== 8'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored got starts=%0d count=%0d done=%b required 1 1 1",
                     starts, write_count, done);
        end
        clear_mon();
        pulse_start();
        checks++;
        if (done !== 1'b0 || write_count !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear got done=%b count=%0d busy=%b required 0 0 1",
                     done, write_count, busy);
        end
        wait_done(3000);
        checks++;
        if (starts !== 1 || write_count !== 8'd1 || {rx[0], rx[1], rx[2]} !== 24'h421280) begin
            errors++;
            $display("FAIL restart_resend got starts=%0d count=%0d bytes=%h%h%h required 1 1 421280",
                     starts, write_count, rx[0], rx[1], rx[2]);
        end
    endtask

    task automatic test_reset_mid();
        int r0, s0;
        load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        clear_mon();
        pulse_start();
        repeat (300) @(negedge clk);
        checks++;
        if (bytecnt >= 3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup got bytecnt=%0d busy=%b required <3 1", bytecnt, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({sioc, siod_oe, busy} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_outputs got sioc/oe/busy=%b required 100", {sioc, siod_oe, busy});
        end
        reset = 1'b0;
        r0 = rises;
        s0 = starts;
        repeat (600) @(negedge clk);
        checks++;
        if (rises !== r0 || starts !== s0 || sioc !== 1'b1 || siod_oe !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet got rises=%0d starts=%0d sioc=%b oe=%b required %0d %0d 1 0",
                     rises, starts, sioc, siod_oe, r0, s0);
        end
    endtask

    task automatic test_nack();
        nack_reg12 = 1'b1;
        load(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
        clear_mon();
        pulse_start();
        wait_done(9000);
`ifdef SCCB_ACK_CHECK_EN
        checks++;
        if (starts !== 4 || rx[1] !== 8'h11) begin
            errors++;
            $display("FAIL nack_retries got starts=%0d last_reg=%h required 4 11", starts, rx[1]);
        end
        checks++;
        if ({nack, done} !== 2'b11 || write_count !== 8'd1) begin
            errors++;
            $display("FAIL nack_status got nack=%b done=%b count=%0d required 1 1 1",
                     nack, done, write_count);
        end
`else
        checks++;
        if (starts !== 2 || rx[1] !== 8'h11) begin
            errors++;
            $display("FAIL nack_ignored got starts=%0d last_reg=%h required 2 11", starts, rx[1]);
        end
        checks++;
        if ({nack, done} !== 2'b01 || write_count !== 8'd2) begin
            errors++;
            $display("FAIL nack_tied got nack=%b done=%b count=%0d required 0 1 2",
                     nack, done, write_count);
        end
`endif
        nack_reg12 = 1'b0;
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL protocol got %0d violations required 0", viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_tab[i] = 16'hFFFF;
        test_reset();
        test_single_write();
        test_delay();
        test_back_to_back();
        test_reset_mid();
        test_nack();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sccb_config_sequencer.md
Name: sccb_config_sequencer

Overview:
- Single-clock SCCB (I2C-like) master that writes the camera sensor's register set after power-up, before the VRAM capture path starts receiving pixel data.
- Walks an external register table (one 16-bit entry per address) and issues one 3-phase SCCB write per entry: device ID, register address, data.
- Supports delay and end markers. Reports busy, done and write count to the top level.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- SCCB_FREQ_HZ, 100_000, SIOC frequency. Quarter-period QTR = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) clocks.
- DEVICE_ADDR, 8'h42, SCCB write ID byte.
- ROM_ADDR_WIDTH, 8, table address width.
- DELAY_CYCLES, 1_000_000, stall length for a delay marker.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse that starts the sequence from table entry 0
- rom_addr_o  out  ROM_ADDR_WIDTH  table address
- rom_data_i  in  16  table entry; [15:8] register address, [7:0] data
- sioc_o  out  1  SCCB clock
- siod_o  out  1  SIOD drive value
- siod_oe_o  out  1  1 = drive SIOD; 0 = release (external pull-up)
- siod_i  in  1  sampled SIOD pin
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence finished; held until next start or reset
- nack_o  out  1  sticky NACK error
- write_count_o  out  ROM_ADDR_WIDTH  completed writes in the current run

Behaviour:
- Reset values: sioc_o=1, siod_o=1, siod_oe_o=0, busy_o=0, done_o=0, nack_o=0, rom_addr_o=0, write_count_o=0. State is IDLE.
- Reset mid-transaction: all of the above take effect on the next clock edge. No STOP is generated.
- States: IDLE, FETCH, DECODE, START, BIT, STOP, GAP, DELAY, DONE.
- IDLE or DONE, start_i=1:
  - rom_addr_o=0, write_count_o=0, done_o=0, nack_o=0, busy_o=1.
  - Go to FETCH.
- start_i in any other state is ignored.
- ROM latency is 1 clock. FETCH holds rom_addr_o for one cycle; DECODE samples rom_data_i.
- DECODE:
  - 16'hFFFF: go to DONE. done_o=1, busy_o=0.
  - 16'hFFF0: go to DELAY. Count DELAY_CYCLES clocks, increment rom_addr_o, go to FETCH.
  - Otherwise: latch the entry and go to START.
- START (2 QTR):
  - SIOC high and SIOD driven 1, then SIOD driven 0.
  - Then SIOC low.
- BIT:
  - 27 bit slots: 3 bytes x (8 data bits MSB-first + 1 don't-care/ack bit). Byte order is DEVICE_ADDR, register address, data.
  - Each slot is 4 QTR phases: Q0 SIOC low with SIOD updated; Q1 low; Q2 high; Q3 high.
  - SIOD changes only in Q0.
  - 9th bit of each byte: siod_oe_o=0.
- STOP (3 QTR): SIOC low with SIOD 0; SIOC high; SIOD released (oe=0, bus high).
- GAP (4 QTR), bus idle. Then:
  - write_count_o+1 and rom_addr_o+1, go to FETCH.
  - If rom_addr_o was already all-ones, go to DONE instead (wrap guard). No address wrap occurs.
- QTR counter reloads on every state entry. SIOC period is exactly 4*QTR clocks.

Optional Feature:
- Macro: SCCB_ACK_CHECK_EN.
- Defined:
  - siod_i is sampled at the Q2 rising SIOC edge of each 9th bit; 1 = NACK.
  - On any NACK, finish the current transaction through STOP and GAP without incrementing, then retry the same entry.
  - After 3 failed attempts: set nack_o=1, skip the entry (no count increment), continue with the next entry.
- Undefined: siod_i is ignored and nack_o is tied 0. No retries.

Test Plan (CLK_FREQ_HZ=400, SCCB_FREQ_HZ=10 so QTR=10, DELAY_CYCLES=50, SCCB slave model ACKs unless stated):
- Table {16'h1280, 16'hFFFF}, pulse start_i:
  - monitor decodes bytes 0x42, 0x12, 0x80 with one START and one STOP;
  - write_count_o=1, done_o=1, busy_o=0;
  - SIOC period 40 clocks.
- Table {16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF}:
  - second START begins ≥50+40 clocks after the first STOP completes;
  - write_count_o=2.
- start_i pulse mid-transaction: no effect, single write observed. A second start_i after done_o: done_o clears, count restarts, same bytes re-sent.
- reset_i asserted during a data bit: next cycle sioc_o=1, siod_oe_o=0, busy_o=0; no further bus activity until start_i.
- Protocol checker over all runs: SIOD edges while SIOC high occur only as START (falling) or STOP (rising); siod_oe_o=0 in every 9th slot.
- SCCB_ACK_CHECK_EN defined, slave NACKs register 0x12 always:
  - 3 transactions for 0x12, then 0x1101 written;
  - nack_o=1, write_count_o=1, done_o=1.
